// File: rtl/store_formatter_pkg.sv
// store_formatter_pkg: memory-stage opcodes, store FSM states, request payload
// and small helpers shared by the store formatter and its lane merge.
package store_formatter_pkg;

    localparam int unsigned OP_W   = 6;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned BE_W   = 4;
    localparam int unsigned LANE_W = 2;

    // Load opcodes used by the sign/zero-extension path.
    localparam logic [OP_W-1:0] OP_LB  = 6'b100000;
    localparam logic [OP_W-1:0] OP_LH  = 6'b100001;
    localparam logic [OP_W-1:0] OP_LW  = 6'b100011;
    localparam logic [OP_W-1:0] OP_LBU = 6'b100100;
    localparam logic [OP_W-1:0] OP_LHU = 6'b100101;

    // Store opcodes handled by the store formatter.
    localparam logic [OP_W-1:0] OP_SB  = 6'b101000;
    localparam logic [OP_W-1:0] OP_SH  = 6'b101001;
    localparam logic [OP_W-1:0] OP_SW  = 6'b101011;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD     = 2'd1,
        WR     = 2'd2,
        REJECT = 2'd3
    } state_t;

    // Store request as latched on acceptance.
    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [LANE_W-1:0] lane;
        logic [WORD_W-1:0] data;
    } store_req_t;

    // True for any load opcode of the memory stage.
    function automatic logic is_load(input logic [OP_W-1:0] op);
        return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
               (op == OP_LBU) || (op == OP_LHU);
    endfunction

    // True for a known store whose address is naturally aligned.
    function automatic logic store_aligned(input logic [OP_W-1:0] op,
                                           input logic [LANE_W-1:0] lane);
        case (op)
            OP_SB:   return 1'b1;
            OP_SH:   return ~lane[0];
            OP_SW:   return lane == 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    // Store data copied into every lane it may land in.
    function automatic logic [WORD_W-1:0] store_replicate(input logic [OP_W-1:0] op,
                                                          input logic [WORD_W-1:0] data);
        case (op)
            OP_SB:   return {4{data[7:0]}};
            OP_SH:   return {2{data[15:0]}};
            default: return data;
        endcase
    endfunction

endpackage

// File: rtl/store_lane_merge.sv
// store_lane_merge: drops store data into its lane of an existing word and
// produces the matching byte enables (all ones for read-modify-write use).
module store_lane_merge
    import store_formatter_pkg::*;
(
    input  logic              rmw,
    input  logic [WORD_W-1:0] old_word,
    input  logic [WORD_W-1:0] st_data,
    input  logic [OP_W-1:0]   op,
    input  logic [LANE_W-1:0] lane,
    output logic [WORD_W-1:0] merged,
    output logic [BE_W-1:0]   be
);

    // Lane replacement and byte-enable generation.
    always_comb begin
        merged = old_word;
        be     = '0;
        case (op)
            OP_SB: begin
                merged[{lane, 3'b000} +: 8] = st_data[7:0];
                be = BE_W'(4'b0001 << lane);
            end
            OP_SH: begin
                merged[{lane[1], 4'b0000} +: 16] = st_data[15:0];
                be = lane[1] ? 4'b1100 : 4'b0011;
            end
            OP_SW: begin
                merged = st_data;
                be     = 4'b1111;
            end
            default: begin
                merged = old_word;
                be     = '0;
            end
        endcase
        if (rmw) begin
            be = 4'b1111;
        end
    end

endmodule

// File: rtl/store_formatter.sv
// store_formatter: accepts one SB/SH/SW, checks alignment and writes the lane
// into word-wide memory by read-modify-write. Defining
// STORE_FORMATTER_BYTE_EN_EN switches to single byte-enabled writes (no read).
module store_formatter
    import store_formatter_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              st_valid,
    output logic              st_ready,
    input  logic [OP_W-1:0]   instruccion,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [DATA_W-1:0] st_data,
    output logic              st_done,
    output logic              st_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_wr_en,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [BE_W-1:0]   mem_be,
    input  logic              mem_ready
);

`ifdef STORE_FORMATTER_BYTE_EN_EN
    localparam bit RMW_MODE = 1'b0;
`else
    localparam bit RMW_MODE = 1'b1;
`endif

    state_t            state;
    store_req_t        req_q;
    logic [OP_W-1:0]   sel_op_c;
    logic [LANE_W-1:0] sel_lane_c;
    logic [WORD_W-1:0] sel_data_c;
    logic [WORD_W-1:0] old_word_c;
    logic [WORD_W-1:0] merged_c;
    logic [BE_W-1:0]   be_c;
    logic              accept_c;
    logic              aligned_c;

    // Merge operands: live request while idle, latched request afterwards.
    always_comb begin
        sel_op_c   = req_q.op;
        sel_lane_c = req_q.lane;
        sel_data_c = req_q.data;
        if (state == IDLE) begin
            sel_op_c   = instruccion;
            sel_lane_c = st_addr[1:0];
            sel_data_c = st_data;
        end
        old_word_c = (state == RD) ? mem_rdata : store_replicate(sel_op_c, sel_data_c);
    end

    assign accept_c  = st_valid && st_ready;
    assign aligned_c = store_aligned(instruccion, st_addr[1:0]);

    store_lane_merge u_merge (
        .rmw      (RMW_MODE),
        .old_word (old_word_c),
        .st_data  (sel_data_c),
        .op       (sel_op_c),
        .lane     (sel_lane_c),
        .merged   (merged_c),
        .be       (be_c)
    );

    // Store FSM with registered handshake and memory-port outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            req_q      <= '0;
            st_ready   <= 1'b0;
            st_done    <= 1'b0;
            st_err     <= 1'b0;
            mem_addr   <= '0;
            mem_rd_en  <= 1'b0;
            mem_wr_en  <= 1'b0;
            mem_wdata  <= '0;
            mem_be     <= '0;
        end else begin
            st_done <= 1'b0;
            st_err  <= 1'b0;
            case (state)
                IDLE: begin
                    st_ready <= 1'b1;
                    mem_be   <= '0;
                    if (accept_c) begin
                        st_ready   <= 1'b0;
                        req_q.op   <= instruccion;
                        req_q.lane <= st_addr[1:0];
                        req_q.data <= st_data;
                        mem_addr   <= {st_addr[ADDR_W-1:2], 2'b00};
                        if (!aligned_c) begin
                            state   <= REJECT;
                            st_done <= 1'b1;
                            st_err  <= 1'b1;
                        end else if (RMW_MODE && (instruccion != OP_SW)) begin
                            state     <= RD;
                            mem_rd_en <= 1'b1;
                            mem_be    <= be_c;
                        end else begin
                            state     <= WR;
                            mem_wr_en <= 1'b1;
                            mem_wdata <= merged_c;
                            mem_be    <= be_c;
                        end
                    end
                end
                RD: begin
                    if (mem_ready) begin
                        state     <= WR;
                        mem_rd_en <= 1'b0;
                        mem_wr_en <= 1'b1;
                        mem_wdata <= merged_c;
                    end
                end
                WR: begin
                    if (mem_ready) begin
                        state     <= IDLE;
                        mem_wr_en <= 1'b0;
                        mem_be    <= '0;
                        st_done   <= 1'b1;
                    end
                end
                REJECT: begin
                    state    <= IDLE;
                    st_ready <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_store_formatter.sv
// tb_store_formatter: table vectors, hand sequences for reset and back-to-back,
// and random stores checked against a word-level memory model.
module tb_store_formatter;

    localparam logic [5:0] SB = 6'b101000;
    localparam logic [5:0] SH = 6'b101001;
    localparam logic [5:0] SW = 6'b101011;
    localparam int MEM_WORDS  = 16384;
`ifdef STORE_FORMATTER_BYTE_EN_EN
    localparam bit BE_MODE = 1'b1;
`else
    localparam bit BE_MODE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        st_valid;
    logic        st_ready;
    logic [5:0]  instruccion;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        st_done;
    logic        st_err;
    logic [31:0] mem_addr;
    logic        mem_rd_en;
    logic [31:0] mem_rdata;
    logic        mem_wr_en;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ready;

    always #5 clk = ~clk;

    store_formatter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .st_valid    (st_valid),
        .st_ready    (st_ready),
        .instruccion (instruccion),
        .st_addr     (st_addr),
        .st_data     (st_data),
        .st_done     (st_done),
        .st_err      (st_err),
        .mem_addr    (mem_addr),
        .mem_rd_en   (mem_rd_en),
        .mem_rdata   (mem_rdata),
        .mem_wr_en   (mem_wr_en),
        .mem_wdata   (mem_wdata),
        .mem_be      (mem_be),
        .mem_ready   (mem_ready)
    );

    // ---------------- memory responder ----------------
    logic [31:0] mem [MEM_WORDS];
    bit          written [MEM_WORDS];
    int          wait_cnt = 0;
    int          stall_n  = 0;
    logic [13:0] midx;
    logic [31:0] be_mask;
    logic [31:0] wr_word;

    function automatic logic [31:0] init_word(input int idx);
        return (32'(idx) * 32'h9E3779B1) ^ 32'h5A5AA5A5;
    endfunction

    assign midx      = mem_addr[15:2];
    assign mem_rdata = written[midx] ? mem[midx] : init_word(int'(midx));
    assign mem_ready = (mem_rd_en || mem_wr_en) && (wait_cnt >= stall_n);

    always_comb begin
        be_mask = {{8{mem_be[3]}}, {8{mem_be[2]}}, {8{mem_be[1]}}, {8{mem_be[0]}}};
        wr_word = BE_MODE ? ((mem_rdata & ~be_mask) | (mem_wdata & be_mask)) : mem_wdata;
    end

    always @(posedge clk) begin
        if (mem_wr_en && mem_ready) begin
            mem[midx]     <= wr_word;
            written[midx] <= 1'b1;
        end
        if ((mem_rd_en || mem_wr_en) && !mem_ready) wait_cnt <= wait_cnt + 1;
        else                                        wait_cnt <= 0;
    end

    function automatic logic [31:0] mem_word(input int idx);
        return written[idx] ? mem[idx] : init_word(idx);
    endfunction

    // ---------------- bus monitor ----------------
    int          rd_cyc = 0;
    int          wr_cyc = 0;
    int          viol   = 0;
    logic [3:0]  last_wr_be   = '0;
    logic [31:0] last_wr_addr = '0;
    logic        prev_rd = 1'b0;
    logic        prev_wr = 1'b0;
    logic [67:0] prev_bus = '0;

    always @(negedge clk) begin
        if (mem_rd_en) rd_cyc <= rd_cyc + 1;
        if (mem_wr_en) begin
            wr_cyc       <= wr_cyc + 1;
            last_wr_be   <= mem_be;
            last_wr_addr <= mem_addr;
        end
        if ((mem_rd_en && mem_wr_en) ||
            (((mem_rd_en && prev_rd) || (mem_wr_en && prev_wr)) &&
             ({mem_addr, mem_be, mem_wdata} != prev_bus)) ||
            (mem_rd_en && mem_be != 4'hF))
            viol <= viol + 1;
        prev_rd  <= mem_rd_en;
        prev_wr  <= mem_wr_en;
        prev_bus <= {mem_addr, mem_be, mem_wdata};
    end

    // ---------------- reference model ----------------
    logic [31:0] mdl [MEM_WORDS];
    bit          mdl_wr [MEM_WORDS];

    function automatic logic [31:0] mdl_read(input int idx);
        return mdl_wr[idx] ? mdl[idx] : init_word(idx);
    endfunction

    function automatic logic [31:0] model_merge(input logic [31:0] old, input logic [5:0] op,
                                                input int lane, input logic [31:0] data);
        logic [31:0] mask;
        logic [31:0] ins;
        if (op == SB) begin
            mask = 32'hFF << (8 * lane);
            ins  = (data & 32'hFF) << (8 * lane);
        end else if (op == SH) begin
            mask = 32'hFFFF << (8 * lane);
            ins  = (data & 32'hFFFF) << (8 * lane);
        end else begin
            mask = 32'hFFFF_FFFF;
            ins  = data;
        end
        return (old & ~mask) | ins;
    endfunction

    function automatic bit model_err(input logic [5:0] op, input logic [31:0] addr);
        if (op == SB) return 1'b0;
        if (op == SH) return (addr % 2) != 0;
        if (op == SW) return (addr % 4) != 0;
        return 1'b1;
    endfunction

    function automatic int lat_of(input bit err, input logic [5:0] op, input int stall);
        if (err) return 0;
        if (BE_MODE || op == SW) return 1 + stall;
        return 2 + 2 * stall;
    endfunction

    function automatic logic [3:0] exp_be(input logic [5:0] op, input int lane);
        if (!BE_MODE) return 4'hF;
        if (op == SB) return 4'(1 << lane);
        if (op == SH) return (lane >= 2) ? 4'hC : 4'h3;
        return 4'hF;
    endfunction

    task automatic model_store(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] data);
        int idx;
        idx         = int'(addr[15:2]);
        mdl[idx]    = model_merge(mdl_read(idx), op, int'(addr[1:0]), data);
        mdl_wr[idx] = 1'b1;
    endtask

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, got, want);
        end
    endtask

    task automatic do_store(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] data,
                            input int stall, input bit exp_err, input int exp_lat,
                            input bit chk_word, input logic [31:0] exp_word);
        int g;
        int lat;
        int rd0;
        int wr0;
        int v0;
        int exp_rd;
        int exp_wr;
        int idx;
        idx     = int'(addr[15:2]);
        stall_n = stall;
        @(negedge clk);
        st_valid    = 1'b1;
        instruccion = op;
        st_addr     = addr;
        st_data     = data;
        g = 0;
        while (!st_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        chk("accept_ready", 32'(st_ready), 32'd1);
        @(posedge clk); #1;
        rd0 = rd_cyc;
        wr0 = wr_cyc;
        v0  = viol;
        st_valid    = 1'b0;
        instruccion = 6'($urandom);
        st_addr     = $urandom;
        st_data     = $urandom;
        lat = 0;
        while (!st_done && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("done_latency", 32'(lat), 32'(exp_lat));
        chk("st_err", 32'(st_err), 32'(exp_err));
        chk("ready_low_in_done", 32'(st_ready), 32'd0);
        @(posedge clk); #1;
        chk("done_one_cycle", 32'({st_done, st_err}), 32'd0);
        chk("ready_after_done", 32'(st_ready), 32'd1);
        exp_rd = (!exp_err && !BE_MODE && op != SW) ? stall + 1 : 0;
        exp_wr = exp_err ? 0 : stall + 1;
        chk("rd_cycles", 32'(rd_cyc - rd0), 32'(exp_rd));
        chk("wr_cycles", 32'(wr_cyc - wr0), 32'(exp_wr));
        chk("bus_protocol", 32'(viol - v0), 32'd0);
        if (!exp_err) begin
            chk("wr_be", 32'(last_wr_be), 32'(exp_be(op, int'(addr[1:0]))));
            chk("wr_addr", last_wr_addr, {addr[31:2], 2'b00});
            model_store(op, addr, data);
        end
        chk("mem_word", mem_word(idx), mdl_read(idx));
        if (chk_word) chk("mem_word_tbl", mem_word(idx), exp_word);
    endtask

    typedef struct {
        logic [5:0]  op;
        logic [31:0] addr;
        logic [31:0] data;
        int          stall;
        bit          err;
        int          lat_rmw;
        int          lat_be;
        bit          chk_word;
        logic [31:0] word;
    } vec_t;

    vec_t tbl [11];

    initial begin
        int g;
        int lat;
        logic [5:0]  rop;
        logic [31:0] raddr;
        logic [31:0] rdata;
        int          rstall;
        bit          rerr;

        tbl[0]  = '{SW, 32'h1000, 32'h11223344, 0, 1'b0, 1, 1, 1'b1, 32'h11223344};
        tbl[1]  = '{SB, 32'h1002, 32'h000000AB, 0, 1'b0, 2, 1, 1'b1, 32'h11AB3344};
        tbl[2]  = '{SW, 32'h2000, 32'hDEADC0DE, 0, 1'b0, 1, 1, 1'b1, 32'hDEADC0DE};
        tbl[3]  = '{SH, 32'h2002, 32'h0000BEEF, 2, 1'b0, 6, 3, 1'b1, 32'hBEEFC0DE};
        tbl[4]  = '{SW, 32'h3000, 32'hCAFEF00D, 0, 1'b0, 1, 1, 1'b1, 32'hCAFEF00D};
        tbl[5]  = '{SB, 32'h3003, 32'h0000005A, 0, 1'b0, 2, 1, 1'b1, 32'h5AFEF00D};
        tbl[6]  = '{SH, 32'h4001, 32'h00001234, 0, 1'b1, 0, 0, 1'b0, 32'h0};
        tbl[7]  = '{SW, 32'h4002, 32'h12345678, 0, 1'b1, 0, 0, 1'b0, 32'h0};
        tbl[8]  = '{6'b100011, 32'h4000, 32'h87654321, 0, 1'b1, 0, 0, 1'b0, 32'h0};
        tbl[9]  = '{SH, 32'h3000, 32'h11112222, 1, 1'b0, 4, 2, 1'b1, 32'h5AFE2222};
        tbl[10] = '{SB, 32'h3000, 32'hFFFFFF77, 0, 1'b0, 2, 1, 1'b1, 32'h5AFE2277};

        rst_n       = 1'b0;
        st_valid    = 1'b0;
        instruccion = '0;
        st_addr     = '0;
        st_data     = '0;
        stall_n     = 0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_st_ready", 32'(st_ready), 32'd0);
        chk("rst_st_done", 32'({st_done, st_err}), 32'd0);
        chk("rst_enables", 32'({mem_rd_en, mem_wr_en}), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_mem_be", 32'(mem_be), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_reset", 32'(st_ready), 32'd1);

        // Directed vectors
        for (int i = 0; i < 11; i++) begin
            do_store(tbl[i].op, tbl[i].addr, tbl[i].data, tbl[i].stall, tbl[i].err,
                     BE_MODE ? tbl[i].lat_be : tbl[i].lat_rmw, tbl[i].chk_word, tbl[i].word);
        end

        // Reset while a write is stalled
        stall_n = 0;
        @(negedge clk);
        st_valid    = 1'b1;
        instruccion = SB;
        st_addr     = 32'h5005;
        st_data     = 32'h00000077;
        g = 0;
        while (!st_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        @(posedge clk); #1;
        st_valid = 1'b0;
        g = 0;
        while (!mem_wr_en && g < 20) begin
            @(negedge clk);
            g++;
        end
        chk("rst_reach_wr", 32'(mem_wr_en), 32'd1);
        stall_n = 1000;
        rst_n   = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid_enables", 32'({mem_rd_en, mem_wr_en}), 32'd0);
        chk("rst_mid_no_done", 32'({st_done, st_err}), 32'd0);
        chk("rst_mid_ready", 32'(st_ready), 32'd0);
        chk("rst_mid_no_write", mem_word(int'(st_addr[15:2]) * 0 + 32'h5005 / 4), mdl_read(32'h5005 / 4));
        @(negedge clk);
        rst_n   = 1'b1;
        stall_n = 0;
        @(posedge clk); #1;
        chk("rst_mid_ready_back", 32'(st_ready), 32'd1);
        do_store(SB, 32'h5005, 32'h00000077, 0, 1'b0, lat_of(1'b0, SB, 0), 1'b0, 32'h0);

        // Back-to-back with st_valid held high
        stall_n = 0;
        @(negedge clk);
        st_valid    = 1'b1;
        instruccion = SB;
        st_addr     = 32'h10;
        st_data     = 32'h000000AA;
        g = 0;
        while (!st_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        @(posedge clk); #1;
        st_addr = 32'h11;
        st_data = 32'h000000BB;
        lat = 0;
        while (!st_done && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("b2b_first_latency", 32'(lat), 32'(lat_of(1'b0, SB, 0)));
        chk("b2b_ready_in_done", 32'(st_ready), 32'd0);
        @(posedge clk); #1;
        chk("b2b_ready_next", 32'(st_ready), 32'd1);
        @(posedge clk); #1;
        chk("b2b_second_accept", 32'({st_ready, mem_rd_en || mem_wr_en}), 32'd1);
        st_valid = 1'b0;
        lat = 0;
        while (!st_done && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("b2b_second_latency", 32'(lat), 32'(lat_of(1'b0, SB, 0)));
        model_store(SB, 32'h10, 32'h000000AA);
        model_store(SB, 32'h11, 32'h000000BB);
        chk("b2b_word", mem_word(4), mdl_read(4));

        // Random stores against the model
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: rop = SB;
                3, 4, 5: rop = SH;
                6, 7, 8: rop = SW;
                default: begin
                    rop = 6'($urandom);
                    if (rop == SB || rop == SH || rop == SW) rop = 6'b000000;
                end
            endcase
            raddr  = 32'($urandom_range(0, 32'hFFFF));
            rdata  = $urandom;
            rstall = $urandom_range(0, 2);
            rerr   = model_err(rop, raddr);
            do_store(rop, raddr, rdata, rstall, rerr, lat_of(rerr, rop, rstall), 1'b0, 32'h0);
        end

        chk("bus_protocol_total", 32'(viol), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
